// File: rtl/bp_resolve_queue.sv
// ---------------------------------------------------------------------------
// bp_resolve_queue
//
// Branch-resolution stage behind the global branch predictor. Every
// prediction made at fetch is pushed into an in-order queue of
// {prediction, tag}. When a branch resolves, the head entry is popped and
// compared with the actual outcome. The stage then drives the predictor's
// training strobe and direction, plus a one-cycle mispredict/flush pulse,
// and keeps saturating performance counters.
//
// Ports
//   CLK, RESET            clock; synchronous active-low reset
//   Pred_Valid/Pred/Pred_Tag          push a fetch-time prediction
//   Resolve_Valid/Resolve_Taken/Resolve_Tag  resolve (pop) the oldest branch
//   Flush                 drop every queued (wrong-path) prediction
//   Is_Branch/Is_Taken    registered training strobe/direction to predictor
//   Mispredict            registered one-cycle pulse, wrong or unmatched
//   Full/Empty            queue occupancy, decoded from registered count
//   Overflow/Sync_Error   sticky diagnostics, cleared only by reset
//   Branch_Count/Mispredict_Count     saturating performance counters
//
// Transfer semantics: Pred_Valid and Resolve_Valid are single-cycle strobes
// with no ready/backpressure. Every cycle one is high at a rising edge is
// exactly one transaction. The producer must keep outstanding branches
// <= DEPTH; Overflow only records that this was violated.
// ---------------------------------------------------------------------------
module bp_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Pred_Valid,
  input  logic             Pred,
  input  logic [TAG_W-1:0] Pred_Tag,
  input  logic             Resolve_Valid,
  input  logic             Resolve_Taken,
  input  logic [TAG_W-1:0] Resolve_Tag,
  input  logic             Flush,
  output logic             Is_Branch,
  output logic             Is_Taken,
  output logic             Mispredict,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow,
  output logic             Sync_Error,
  output logic [CNT_W-1:0] Branch_Count,
  output logic [CNT_W-1:0] Mispredict_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic             pred_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             head_pred;
  logic [TAG_W-1:0] head_tag;
  logic             pop;
  logic             push;
  logic             drop;
  logic             tag_miss;
  logic             misp;
  logic             sync_set;

  assign Full  = (count == FULL_CNT);
  assign Empty = (count == '0);

  always_comb begin
    head_pred = pred_mem[rd_ptr];
    head_tag  = tag_mem[rd_ptr];
    // A resolve only pops a real entry. An entry pushed this same cycle is
    // not yet visible, so a resolve against an empty queue stays unmatched.
    pop       = Resolve_Valid & ~Empty;
    // A pop in the same cycle frees a slot, so a push while full is legal.
    // A push that arrives with Flush is wrong-path and is discarded.
    push      = Pred_Valid & (~Full | pop) & ~Flush;
    drop      = Pred_Valid & Full & ~pop & ~Flush;
    tag_miss  = pop & (head_tag != Resolve_Tag);
    // Resolve is scored against the pre-flush head even when Flush is set.
    misp      = Resolve_Valid & (Empty | (head_pred != Resolve_Taken) | tag_miss);
    sync_set  = Resolve_Valid & (Empty | tag_miss);
  end

  // Entry storage. The contents do not matter out of reset; only pointers
  // and count say what is live.
  always_ff @(posedge CLK) begin
    if (push) begin
      pred_mem[wr_ptr] <= Pred;
      tag_mem[wr_ptr]  <= Pred_Tag;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      Is_Branch        <= 1'b0;
      Is_Taken         <= 1'b0;
      Mispredict       <= 1'b0;
      Overflow         <= 1'b0;
      Sync_Error       <= 1'b0;
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else begin
      Is_Branch  <= Resolve_Valid;
      Is_Taken   <= Resolve_Valid & Resolve_Taken;
      Mispredict <= misp;

      if (drop)     Overflow   <= 1'b1;
      if (sync_set) Sync_Error <= 1'b1;

      if (Resolve_Valid && (Branch_Count != '1))
        Branch_Count <= Branch_Count + CNT_W'(1);
      if (misp && (Mispredict_Count != '1))
        Mispredict_Count <= Mispredict_Count + CNT_W'(1);

      if (Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)
          count <= count + (PTR_W+1)'(1);
        else if (pop && !push)
          count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// ---------------------------------------------------------------------------
// tb_bp_resolve_queue
//
// Directed bench for bp_resolve_queue. The driver tasks push the expected
// {Is_Taken, Mispredict} of every resolve into exp_q. A negedge monitor pops
// an entry whenever Is_Branch is seen. Status outputs and counters are
// checked inline. A second instance with CNT_W=4 shares the stimulus and is
// used for counter saturation.
// ---------------------------------------------------------------------------
module tb_bp_resolve_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;

  logic             CLK;
  logic             RESET;
  logic             Pred_Valid;
  logic             Pred;
  logic [TAG_W-1:0] Pred_Tag;
  logic             Resolve_Valid;
  logic             Resolve_Taken;
  logic [TAG_W-1:0] Resolve_Tag;
  logic             Flush;

  logic             Is_Branch, Is_Taken, Mispredict, Full, Empty, Overflow, Sync_Error;
  logic [31:0]      Branch_Count, Mispredict_Count;

  logic             s_is_branch, s_is_taken, s_mispredict, s_full, s_empty, s_overflow, s_sync_error;
  logic [3:0]       s_branch_count, s_mispredict_count;

  logic [1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  bp_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(32)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .Pred_Valid(Pred_Valid), .Pred(Pred), .Pred_Tag(Pred_Tag),
    .Resolve_Valid(Resolve_Valid), .Resolve_Taken(Resolve_Taken), .Resolve_Tag(Resolve_Tag),
    .Flush(Flush),
    .Is_Branch(Is_Branch), .Is_Taken(Is_Taken), .Mispredict(Mispredict),
    .Full(Full), .Empty(Empty), .Overflow(Overflow), .Sync_Error(Sync_Error),
    .Branch_Count(Branch_Count), .Mispredict_Count(Mispredict_Count)
  );

  bp_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(4)) u_sat (
    .CLK(CLK), .RESET(RESET),
    .Pred_Valid(Pred_Valid), .Pred(Pred), .Pred_Tag(Pred_Tag),
    .Resolve_Valid(Resolve_Valid), .Resolve_Taken(Resolve_Taken), .Resolve_Tag(Resolve_Tag),
    .Flush(Flush),
    .Is_Branch(s_is_branch), .Is_Taken(s_is_taken), .Mispredict(s_mispredict),
    .Full(s_full), .Empty(s_empty), .Overflow(s_overflow), .Sync_Error(s_sync_error),
    .Branch_Count(s_branch_count), .Mispredict_Count(s_mispredict_count)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [1:0] e;
    if (Is_Branch === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL train_unexpected: got Is_Branch=1 with no expected resolve at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("train_taken_misp", {30'd0, Is_Taken, Mispredict}, {30'd0, e});
      end
    end else begin
      check("idle_taken_misp", {30'd0, Is_Taken, Mispredict}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    Pred_Valid    = 1'b0;
    Pred          = 1'b0;
    Pred_Tag      = '0;
    Resolve_Valid = 1'b0;
    Resolve_Taken = 1'b0;
    Resolve_Tag   = '0;
    Flush         = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One clock of stimulus. For a resolve the caller supplies the expected
  // mispredict; the expected direction is the resolved direction.
  task automatic drive(input logic pv, input logic p, input logic [TAG_W-1:0] ptag,
                       input logic rv, input logic rt, input logic [TAG_W-1:0] rtag,
                       input logic fl, input logic exp_mis);
    Pred_Valid    = pv;
    Pred          = p;
    Pred_Tag      = ptag;
    Resolve_Valid = rv;
    Resolve_Taken = rt;
    Resolve_Tag   = rtag;
    Flush         = fl;
    if (rv) exp_q.push_back({rt, exp_mis});
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  task automatic push_br(input logic p, input logic [TAG_W-1:0] tag);
    drive(1'b1, p, tag, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic resolve_br(input logic t, input logic [TAG_W-1:0] tag, input logic exp_mis);
    drive(1'b0, 1'b0, '0, 1'b1, t, tag, 1'b0, exp_mis);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    repeat (2) begin
      Pred_Valid    = 1'($urandom_range(0, 1));
      Pred          = 1'($urandom_range(0, 1));
      Pred_Tag      = TAG_W'($urandom_range(0, 63));
      Resolve_Valid = 1'($urandom_range(0, 1));
      Resolve_Taken = 1'($urandom_range(0, 1));
      Resolve_Tag   = TAG_W'($urandom_range(0, 63));
      Flush         = 1'($urandom_range(0, 1));
      @(posedge CLK);
      #1;
    end
    idle_inputs();
    check("rst_is_branch", {31'd0, Is_Branch}, 32'd0);
    check("rst_empty", {31'd0, Empty}, 32'd1);
    check("rst_full", {31'd0, Full}, 32'd0);
    check("rst_overflow", {31'd0, Overflow}, 32'd0);
    check("rst_sync_error", {31'd0, Sync_Error}, 32'd0);
    check("rst_branch_count", Branch_Count, 32'd0);
    check("rst_misp_count", Mispredict_Count, 32'd0);
    RESET = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [TAG_W-1:0] t;
    RESET = 1'b0;
    idle_inputs();
    idle(1);

    // Reset, then idle: the monitor flags any stray Is_Branch pulse.
    do_reset();
    idle(4);

    // In-order match: second resolve disagrees with its Pred=0.
    push_br(1'b1, 6'd3);
    push_br(1'b0, 6'd4);
    resolve_br(1'b1, 6'd3, 1'b0);
    resolve_br(1'b1, 6'd4, 1'b1);
    check("inorder_branch_count", Branch_Count, 32'd2);
    check("inorder_misp_count", Mispredict_Count, 32'd1);
    check("inorder_empty", {31'd0, Empty}, 32'd1);
    check("inorder_sync_error", {31'd0, Sync_Error}, 32'd0);
    idle(2);

    // Full / overflow / wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      t = TAG_W'(i);
      push_br(t[0], t);
      if (i == DEPTH - 2) check("fill_not_full", {31'd0, Full}, 32'd0);
    end
    check("fill_full", {31'd0, Full}, 32'd1);
    check("fill_empty", {31'd0, Empty}, 32'd0);
    push_br(1'b1, 6'd63);
    check("overflow_set", {31'd0, Overflow}, 32'd1);
    check("overflow_full", {31'd0, Full}, 32'd1);
    // Entry k of the stream has tag k and Pred k[0]; the dropped tag-63
    // entry must never surface.
    for (int j = 0; j < 20; j++) begin
      logic [TAG_W-1:0] pt;
      t  = TAG_W'(j);
      pt = TAG_W'(j + DEPTH);
      drive(1'b1, pt[0], pt, 1'b1, t[0], t, 1'b0, 1'b0);
    end
    check("wrap_full", {31'd0, Full}, 32'd1);
    check("wrap_misp_count", Mispredict_Count, 32'd0);
    check("wrap_branch_count", Branch_Count, 32'd20);
    check("wrap_sync_error", {31'd0, Sync_Error}, 32'd0);
    idle(2);

    // Resolve with an empty queue.
    do_reset();
    resolve_br(1'b0, 6'd1, 1'b1);
    check("empty_res_sync_error", {31'd0, Sync_Error}, 32'd1);
    check("empty_res_branch_count", Branch_Count, 32'd1);
    check("empty_res_misp_count", Mispredict_Count, 32'd1);
    idle(2);

    // Tag mismatch with matching direction.
    do_reset();
    push_br(1'b1, 6'd5);
    resolve_br(1'b1, 6'd6, 1'b1);
    check("tagmiss_sync_error", {31'd0, Sync_Error}, 32'd1);
    check("tagmiss_empty", {31'd0, Empty}, 32'd1);
    idle(2);

    // Flush with a same-cycle resolve of the head and a same-cycle push.
    do_reset();
    push_br(1'b1, 6'd10);
    push_br(1'b0, 6'd11);
    push_br(1'b1, 6'd12);
    drive(1'b1, 1'b1, 6'd13, 1'b1, 1'b1, 6'd10, 1'b1, 1'b0);
    check("flush_empty", {31'd0, Empty}, 32'd1);
    check("flush_full", {31'd0, Full}, 32'd0);
    check("flush_overflow", {31'd0, Overflow}, 32'd0);
    check("flush_sync_error", {31'd0, Sync_Error}, 32'd0);
    resolve_br(1'b1, 6'd13, 1'b1);
    check("flush_after_sync_error", {31'd0, Sync_Error}, 32'd1);
    idle(2);

    // Saturation: 20 unmatched resolves.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      resolve_br(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 63)), 1'b1);
    end
    check("sat4_branch_count", {28'd0, s_branch_count}, 32'd15);
    check("sat4_misp_count", {28'd0, s_mispredict_count}, 32'd15);
    check("sat32_branch_count", Branch_Count, 32'd20);
    check("sat32_misp_count", Mispredict_Count, 32'd20);

    idle(3);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
